// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the IF/MEM memory port arbiter: FSM states, owner tags, latency width.
// Pure declarations; no latency or backpressure of its own.
package mem_port_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE        = 2'd0,
        IF_BUSY     = 2'd1,
        LSU_RD_BUSY = 2'd2
    } state_e;

    typedef enum logic {
        OWN_IF  = 1'b0,
        OWN_LSU = 1'b1
    } owner_e;

    localparam int          LAT_W       = 3;
    localparam logic [3:0]  RD_MASK_ALL = 4'hF;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundle of fetch, load/store and memory signals around the arbiter.
// slave = arbiter view, master = pipeline + memory view; handshakes are req/ready per requester.
interface mem_port_arbiter_if;
    logic        i_if_req;
    logic [31:0] i_if_addr;
    logic        i_flush;
    logic        i_lsu_req;
    logic        i_lsu_we;
    logic [31:0] i_lsu_addr;
    logic [31:0] i_lsu_wdata;
    logic [3:0]  i_lsu_wmask;
    logic        o_if_ready;
    logic        o_if_valid;
    logic [31:0] o_if_rdata;
    logic        o_lsu_ready;
    logic        o_lsu_valid;
    logic [31:0] o_lsu_rdata;
    logic        o_mem_req;
    logic        o_mem_we;
    logic [31:0] o_mem_addr;
    logic [31:0] o_mem_wdata;
    logic [3:0]  o_mem_wmask;
    logic [31:0] i_mem_rdata;

    modport slave (
        input  i_if_req, i_if_addr, i_flush,
        input  i_lsu_req, i_lsu_we, i_lsu_addr, i_lsu_wdata, i_lsu_wmask,
        input  i_mem_rdata,
        output o_if_ready, o_if_valid, o_if_rdata,
        output o_lsu_ready, o_lsu_valid, o_lsu_rdata,
        output o_mem_req, o_mem_we, o_mem_addr, o_mem_wdata, o_mem_wmask
    );

    modport master (
        output i_if_req, i_if_addr, i_flush,
        output i_lsu_req, i_lsu_we, i_lsu_addr, i_lsu_wdata, i_lsu_wmask,
        output i_mem_rdata,
        input  o_if_ready, o_if_valid, o_if_rdata,
        input  o_lsu_ready, o_lsu_valid, o_lsu_rdata,
        input  o_mem_req, o_mem_we, o_mem_addr, o_mem_wdata, o_mem_wmask
    );
endinterface

// File: rtl/mem_lat_tracker.sv
// Down-counter tracking one in-flight read: flags the response cycle, holds owner and kill bit.
// Response RD_LAT cycles after issue; no backpressure (memory cannot stall or cancel).
module mem_lat_tracker
    import mem_port_arbiter_pkg::*;
#(
    parameter int RD_LAT = 2
) (
    input  logic   clk_i,
    input  logic   rst_n_i,
    input  logic   issue_i,
    input  owner_e issue_own_i,
    input  logic   flush_i,
    output logic   resp_o,
    output owner_e own_o,
    output logic   kill_o
);

    localparam logic [LAT_W-1:0] LAT_LOAD = LAT_W'(RD_LAT);
    localparam logic [LAT_W-1:0] LAT_ONE  = LAT_W'(1);

    logic [LAT_W-1:0] cnt_q, cnt_d;
    owner_e           own_q, own_d;
    logic             kill_q, kill_d;

    assign resp_o = (cnt_q == LAT_ONE);
    assign own_o  = own_q;
    assign kill_o = kill_q;

    always_comb begin
        cnt_d  = cnt_q;
        own_d  = own_q;
        kill_d = kill_q;
        if (issue_i) begin
            cnt_d  = LAT_LOAD;
            own_d  = issue_own_i;
            kill_d = 1'b0;
        end else begin
            if (cnt_q != '0) cnt_d = cnt_q - LAT_ONE;
            // A flushed fetch still occupies the port; only its data is dropped.
            if (resp_o)
                kill_d = 1'b0;
            else if (flush_i && (cnt_q != '0) && (own_q == OWN_IF))
                kill_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            cnt_q  <= '0;
            own_q  <= OWN_IF;
            kill_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            own_q  <= own_d;
            kill_q <= kill_d;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates fetch and load/store onto one single-port memory, MEM first with bounded IF starvation.
// Read data RD_LAT cycles after grant, stores complete next cycle; requesters stall until their ready.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int RD_LAT      = 2,
    parameter int MAX_MEM_RUN = 4
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    mem_port_arbiter_if.slave bus
);

    localparam logic [3:0] STARVE_MAX = 4'(MAX_MEM_RUN);

    state_e     state_q, state_d;
    logic [3:0] starve_q, starve_d;
    logic       st_vld_q, st_vld_d;

    logic   resp, kill, can_grant, if_elig, if_pri, lsu_gnt, if_gnt, rd_issue;
    owner_e trk_own, issue_own;

    // Reset gates grants combinationally so every output is quiet while reset is held.
    assign can_grant = i_rst_n && ((state_q == IDLE) || resp);
    assign if_elig   = bus.i_if_req && !bus.i_flush;
    assign if_pri    = if_elig && (starve_q == STARVE_MAX);
    assign lsu_gnt   = can_grant && bus.i_lsu_req && !if_pri;
    assign if_gnt    = can_grant && if_elig && !lsu_gnt;
    assign rd_issue  = if_gnt || (lsu_gnt && !bus.i_lsu_we);
    assign issue_own = if_gnt ? OWN_IF : OWN_LSU;

    mem_lat_tracker #(.RD_LAT(RD_LAT)) u_lat (
        .clk_i       (i_clk),
        .rst_n_i     (i_rst_n),
        .issue_i     (rd_issue),
        .issue_own_i (issue_own),
        .flush_i     (bus.i_flush),
        .resp_o      (resp),
        .own_o       (trk_own),
        .kill_o      (kill)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q  <= IDLE;
            starve_q <= '0;
            st_vld_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            starve_q <= starve_d;
            st_vld_q <= st_vld_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (if_gnt)
            state_d = IF_BUSY;
        else if (lsu_gnt)
            state_d = bus.i_lsu_we ? IDLE : LSU_RD_BUSY;
        else if (resp)
            state_d = IDLE;

        starve_d = starve_q;
        if (!bus.i_if_req || if_gnt)
            starve_d = '0;
        else if (lsu_gnt && (starve_q != STARVE_MAX))
            starve_d = starve_q + 4'd1;

        st_vld_d = lsu_gnt && bus.i_lsu_we;
    end

    always_comb begin
        bus.o_if_ready  = if_gnt;
        bus.o_lsu_ready = lsu_gnt;
        bus.o_mem_req   = 1'b0;
        bus.o_mem_we    = 1'b0;
        bus.o_mem_addr  = '0;
        bus.o_mem_wdata = '0;
        bus.o_mem_wmask = '0;
        bus.o_if_valid  = 1'b0;
        bus.o_if_rdata  = '0;
        bus.o_lsu_valid = st_vld_q;
        bus.o_lsu_rdata = '0;

        if (if_gnt) begin
            bus.o_mem_req   = 1'b1;
            bus.o_mem_addr  = bus.i_if_addr;
            bus.o_mem_wmask = RD_MASK_ALL;
        end else if (lsu_gnt) begin
            bus.o_mem_req   = 1'b1;
            bus.o_mem_we    = bus.i_lsu_we;
            bus.o_mem_addr  = bus.i_lsu_addr;
            bus.o_mem_wdata = bus.i_lsu_we ? bus.i_lsu_wdata : '0;
            bus.o_mem_wmask = bus.i_lsu_we ? bus.i_lsu_wmask : RD_MASK_ALL;
        end

        if (resp && (state_q != IDLE)) begin
            if (trk_own == OWN_IF) begin
                if (!kill && !bus.i_flush) begin
                    bus.o_if_valid = 1'b1;
                    bus.o_if_rdata = bus.i_mem_rdata;
                end
            end else begin
                bus.o_lsu_valid = 1'b1;
                bus.o_lsu_rdata = bus.i_mem_rdata;
            end
        end
    end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares one single-port instruction/data memory between the fetch stage (IF) and the load/store stage (MEM) of the RV32 pipeline. It accepts one request per grant, tracks the fixed memory read latency, and routes read data back to the owner. It emits per-requester ready signals that the hazard detection logic turns into IF/IF_ID stalls. Grant priority goes to MEM (the older instruction), with a bounded-starvation guarantee for IF.

## Interface
Parameters:
- RD_LAT, 2: memory read latency in cycles, legal range 1..4.
- MAX_MEM_RUN, 4: maximum consecutive MEM grants while IF is waiting; range 1..15.

Ports:
- i_clk  in  1  clock; all state updates on the rising edge.
- i_rst_n  in  1  reset; asynchronous, active-low.
- i_if_req  in  1  fetch read request; held until o_if_ready.
- i_if_addr  in  32  fetch byte address, word aligned.
- i_flush  in  1  branch taken; kill any pending or in-flight fetch.
- i_lsu_req  in  1  load/store request; held until o_lsu_ready.
- i_lsu_we  in  1  1 = store, 0 = load.
- i_lsu_addr  in  32  load/store byte address.
- i_lsu_wdata  in  32  store data.
- i_lsu_wmask  in  4  store byte enables.
- o_if_ready  out  1  fetch request granted this cycle.
- o_if_valid  out  1  o_if_rdata valid this cycle.
- o_if_rdata  out  32  fetched instruction.
- o_lsu_ready  out  1  load/store request granted this cycle.
- o_lsu_valid  out  1  load data valid, or store complete.
- o_lsu_rdata  out  32  load data; 0 for stores.
- o_mem_req  out  1  memory command strobe.
- o_mem_we  out  1  memory write enable.
- o_mem_addr  out  32  memory address.
- o_mem_wdata  out  32  memory write data.
- o_mem_wmask  out  4  memory byte enables; 4'hF on reads.
- i_mem_rdata  in  32  memory read data, valid RD_LAT cycles after the command.

## Operation
- FSM states: IDLE, IF_BUSY, LSU_RD_BUSY. A store never leaves IDLE.
- Grant is legal in IDLE, or in the response cycle of a busy state, which allows back-to-back issue.
- Priority:
  - MEM wins over IF.
  - If the starvation counter equals MAX_MEM_RUN and i_if_req is high, IF wins.
  - The counter increments on each MEM grant while i_if_req is high.
  - The counter clears on an IF grant or when i_if_req is low.
  - The counter saturates.
- IF grant:
  - Suppressed in any cycle where i_flush is high.
  - On grant: o_if_ready=1, memory command driven combinationally from i_if_addr, go to IF_BUSY, load the latency counter with RD_LAT.
- Load grant: o_lsu_ready=1, command driven, go to LSU_RD_BUSY.
- Store grant:
  - o_lsu_ready=1, o_mem_we=1, mask and data passed through.
  - o_lsu_valid=1 the next cycle; state stays IDLE.
- Latency counter decrements each cycle. The response cycle is the cycle it reaches 1 after issue, i.e. issue cycle T gives response at T+RD_LAT. In that cycle o_*_valid=1 and rdata = i_mem_rdata (combinational pass-through).
- Flush during IF_BUSY:
  - Sets a kill flag; that response's o_if_valid is forced to 0.
  - The FSM still waits out the latency, since memory cannot cancel.
  - The kill flag clears at the response.
- No command when idle: o_mem_req=0, other memory outputs 0.

## Timing
- Reset values: all outputs 0, state IDLE, latency counter 0, starvation counter 0, kill flag 0. o_if_rdata and o_lsu_rdata are 0 while their valid is low.
- Reset asserted mid-operation aborts the transaction. No valid is produced for it after reset releases.
- Load-to-use latency is RD_LAT cycles from grant. With RD_LAT=1 the block sustains one access per cycle.
- Simultaneous IF and store in IDLE: store granted at T, IF granted at T+1 (or IF at T when the starvation counter is at its limit).
- Flush and IF response in the same cycle: o_if_valid=0.
- Requester drops req without ready: nothing is issued (protocol violation; no recovery required).

## Structure
- Shared package: state enum (IDLE, IF_BUSY, LSU_RD_BUSY), owner encoding, and RD_LAT width constant (3 bits).
- One sub-module, mem_lat_tracker: a down-counter that loads on issue, flags the response cycle, and holds the owner and kill bit.

## Test plan
- RD_LAT=2, IF read at 0x100, memory returns 0x00500093 → o_if_ready at T, o_if_valid with 0x00500093 at T+2, no other valid.
- Simultaneous i_if_req and load at 0x2000 → lsu granted at T with o_lsu_valid at T+2; IF granted at T+2 with o_if_valid at T+4.
- Six back-to-back stores with i_if_req held, MAX_MEM_RUN=4 → four stores, then one IF grant, then the remaining stores.
- IF granted, i_flush at T+1 → o_if_valid stays 0 at T+2; next IF grant no earlier than T+2.
- Store 0xDEADBEEF with mask 4'b0011 at 0x40 → o_mem_we=1, o_mem_wmask=4'b0011 at T; o_lsu_valid=1, o_lsu_rdata=0 at T+1.
- i_rst_n pulsed low during LSU_RD_BUSY → all outputs 0 immediately; no o_lsu_valid after release; fresh IF request granted in the first cycle after release.
